// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle CPU: widths, instruction field positions and opcodes.
package cpu_pkg;

  localparam int DATA_W  = 16;
  localparam int NUM_GPR = 32;
  localparam int IR_W    = 32;
  localparam int REG_AW  = $clog2(NUM_GPR);
  localparam int OPC_W   = 5;

  localparam int OPER_MSB  = 31;
  localparam int OPER_LSB  = 27;
  localparam int RDST_MSB  = 26;
  localparam int RDST_LSB  = 22;
  localparam int RSRC1_MSB = 21;
  localparam int RSRC1_LSB = 17;
  localparam int IMM_BIT   = 16;
  localparam int RSRC2_MSB = 15;
  localparam int RSRC2_LSB = 11;
  localparam int ISRC_MSB  = 15;
  localparam int ISRC_LSB  = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_MOVSGPR = 5'd0,
    OP_MOV     = 5'd1,
    OP_ADD     = 5'd2,
    OP_SUB     = 5'd3,
    OP_MUL     = 5'd4,
    OP_OR      = 5'd5,
    OP_AND     = 5'd6,
    OP_XOR     = 5'd7,
    OP_XNOR    = 5'd8,
    OP_NAND    = 5'd9,
    OP_NOR     = 5'd10,
    OP_NOT     = 5'd11
  } opcode_e;

  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result, SGPR (upper product half) and the four condition flags.
// Opcodes 0 (movsgpr) and 4 (mul) exist only when CPU_MUL_EN is defined.
module cpu_alu #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [cpu_pkg::OPC_W-1:0] opcode_i,
  input  logic [DATA_W-1:0]         op1_i,
  input  logic [DATA_W-1:0]         op2_i,
  input  logic [DATA_W-1:0]         sgpr_i,
  output logic                      we_o,
  output logic                      sgpr_we_o,
  output logic [DATA_W-1:0]         result_o,
  output logic [DATA_W-1:0]         sgpr_o,
  output logic                      sign_o,
  output logic                      zero_o,
  output logic                      carry_o,
  output logic                      overflow_o
);
  import cpu_pkg::*;

  localparam int MSB = DATA_W - 1;

  // Extra top bit holds the carry for add and the borrow for sub.
  logic [DATA_W:0] sum;

`ifdef CPU_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = op1_i * op2_i;
`endif

  always_comb begin
    we_o       = 1'b1;
    sgpr_we_o  = 1'b0;
    result_o   = '0;
    sgpr_o     = sgpr_i;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    sum        = '0;
    case (opcode_i)
      OP_MOV:  result_o = op2_i;
      OP_ADD: begin
        sum        = {1'b0, op1_i} + {1'b0, op2_i};
        result_o   = sum[MSB:0];
        carry_o    = sum[DATA_W];
        overflow_o = (op1_i[MSB] == op2_i[MSB]) && (sum[MSB] != op1_i[MSB]);
      end
      OP_SUB: begin
        sum        = {1'b0, op1_i} - {1'b0, op2_i};
        result_o   = sum[MSB:0];
        carry_o    = sum[DATA_W];
        overflow_o = (op1_i[MSB] != op2_i[MSB]) && (sum[MSB] != op1_i[MSB]);
      end
      OP_OR:   result_o = op1_i | op2_i;
      OP_AND:  result_o = op1_i & op2_i;
      OP_XOR:  result_o = op1_i ^ op2_i;
      OP_XNOR: result_o = ~(op1_i ^ op2_i);
      OP_NAND: result_o = ~(op1_i & op2_i);
      OP_NOR:  result_o = ~(op1_i | op2_i);
      OP_NOT:  result_o = ~op2_i;
`ifdef CPU_MUL_EN
      OP_MOVSGPR: result_o = sgpr_i;
      OP_MUL: begin
        result_o  = prod[MSB:0];
        sgpr_o    = prod[2*DATA_W-1:DATA_W];
        sgpr_we_o = 1'b1;
      end
`endif
      default: we_o = 1'b0;
    endcase
  end

  assign sign_o = result_o[MSB];
  assign zero_o = (result_o == '0);

endmodule

// File: rtl/cpu_top.sv
// Single-cycle CPU: IR, register file, SGPR and flags, all updated on an accepted instruction.
// Optional multiplier (opcodes 0 and 4) enabled by defining CPU_MUL_EN.
module cpu_top #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int NUM_GPR = cpu_pkg::NUM_GPR,
  parameter int IR_W    = cpu_pkg::IR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  input  logic [IR_W-1:0]            instr_in,
  input  logic [$clog2(NUM_GPR)-1:0] dbg_addr,
  output logic [DATA_W-1:0]          dbg_data,
  output logic [DATA_W-1:0]          dbg_sgpr,
  output logic                       flag_sign,
  output logic                       flag_zero,
  output logic                       flag_carry,
  output logic                       flag_overflow
);
  import cpu_pkg::*;

  localparam int AW = $clog2(NUM_GPR);

  logic [IR_W-1:0]   ir_q;
  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] sgpr_q;
  flags_t            flags_q;

  logic [OPC_W-1:0]              opcode;
  logic [AW-1:0]                 rdst;
  logic [AW-1:0]                 rsrc1;
  logic [AW-1:0]                 rsrc2;
  logic                          imm_mode;
  logic [ISRC_MSB-ISRC_LSB:0]    isrc;
  logic [DATA_W-1:0]             operand1;
  logic [DATA_W-1:0]             operand2;

  logic              gpr_we;
  logic              sgpr_we;
  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] sgpr_d;
  flags_t            flags_d;

  // Decode straight from the incoming word so the result lands on the same edge.
  assign opcode   = instr_in[OPER_MSB:OPER_LSB];
  assign rdst     = instr_in[RDST_MSB:RDST_LSB];
  assign rsrc1    = instr_in[RSRC1_MSB:RSRC1_LSB];
  assign rsrc2    = instr_in[RSRC2_MSB:RSRC2_LSB];
  assign imm_mode = instr_in[IMM_BIT];
  assign isrc     = instr_in[ISRC_MSB:ISRC_LSB];

  assign operand1 = gpr_q[rsrc1];
  assign operand2 = imm_mode ? DATA_W'(isrc) : gpr_q[rsrc2];

  cpu_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .opcode_i  (opcode),
    .op1_i     (operand1),
    .op2_i     (operand2),
    .sgpr_i    (sgpr_q),
    .we_o      (gpr_we),
    .sgpr_we_o (sgpr_we),
    .result_o  (result_d),
    .sgpr_o    (sgpr_d),
    .sign_o    (flags_d.sign),
    .zero_o    (flags_d.zero),
    .carry_o   (flags_d.carry),
    .overflow_o(flags_d.overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q    <= '0;
      sgpr_q  <= '0;
      flags_q <= '0;
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (instr_valid) begin
      ir_q <= instr_in;
      if (gpr_we) begin
        gpr_q[rdst] <= result_d;
        flags_q     <= flags_d;
      end
      if (sgpr_we) begin
        sgpr_q <= sgpr_d;
      end
    end
  end

  // IR is held as architectural state but nothing downstream consumes it.
  logic ir_unused;
  assign ir_unused = ^ir_q;

  assign dbg_data      = gpr_q[dbg_addr];
  assign dbg_sgpr      = sgpr_q;
  assign flag_sign     = flags_q.sign;
  assign flag_zero     = flags_q.zero;
  assign flag_carry    = flags_q.carry;
  assign flag_overflow = flags_q.overflow;

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: directed flag cases, multiplier, random ops against an
// arithmetic reference model, hold behaviour and asynchronous reset.
module tb_cpu_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_in = '0;
  logic [4:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic [15:0] dbg_sgpr;
  logic        flag_sign, flag_zero, flag_carry, flag_overflow;
  logic [3:0]  dut_flags;

  int checks = 0;
  int errors = 0;

  // Reference model state as plain integers.
  int m_gpr [32];
  int m_sgpr;
  logic [3:0] m_flags;

  // Directed flag scenarios: GPR0=a, GPR1=b, then op GPR2 = GPR0 op GPR1.
  int         d_a   [4] = '{'h8000, 0, 'h8000, 1};
  int         d_b   [4] = '{0, 0, 'h8002, 2};
  int         d_op  [4] = '{2, 2, 2, 3};
  int         d_res [4] = '{'h8000, 0, 'h0002, 'hFFFF};
  logic [3:0] d_fl  [4] = '{4'b1000, 4'b0100, 4'b0011, 4'b1010};

  assign dut_flags = {flag_sign, flag_zero, flag_carry, flag_overflow};

  cpu_top dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_in     (instr_in),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .dbg_sgpr     (dbg_sgpr),
    .flag_sign    (flag_sign),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .flag_overflow(flag_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input bit imm, input int src);
    logic [31:0] w;
    w        = '0;
    w[31:27] = op[4:0];
    w[26:22] = rd[4:0];
    w[21:17] = rs1[4:0];
    w[16]    = imm;
    if (imm) w[15:0] = src[15:0];
    else     w[15:11] = src[4:0];
    return w;
  endfunction

  function automatic int sx(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 0;
    m_sgpr  = 0;
    m_flags = 4'b0000;
  endtask

  // Computes the architectural effect of one instruction with integer arithmetic.
  task automatic model_exec(input logic [31:0] ins);
    int  op   = int'(ins[31:27]);
    int  rd   = int'(ins[26:22]);
    int  rs1  = int'(ins[21:17]);
    int  rs2  = int'(ins[15:11]);
    int  a    = m_gpr[rs1];
    int  b    = ins[16] ? int'(ins[15:0]) : m_gpr[rs2];
    logic [15:0] la = a[15:0];
    logic [15:0] lb = b[15:0];
    logic [15:0] t;
    longint r = 0;
    longint p;
    bit  wr = 1'b1;
    bit  c = 1'b0;
    bit  v = 1'b0;
    case (op)
`ifdef CPU_MUL_EN
      0: r = m_sgpr;
      4: begin
        p      = longint'(a) * longint'(b);
        r      = p % 65536;
        m_sgpr = int'(p / 65536);
      end
`endif
      1: r = b;
      2: begin
        r = a + b;
        c = (r > 65535);
        v = (sx(a) + sx(b) > 32767) || (sx(a) + sx(b) < -32768);
      end
      3: begin
        r = a - b;
        c = (a < b);
        v = (sx(a) - sx(b) > 32767) || (sx(a) - sx(b) < -32768);
      end
      5:  begin t = la | lb;     r = t; end
      6:  begin t = la & lb;     r = t; end
      7:  begin t = la ^ lb;     r = t; end
      8:  begin t = ~(la ^ lb);  r = t; end
      9:  begin t = ~(la & lb);  r = t; end
      10: begin t = ~(la | lb);  r = t; end
      11: begin t = ~lb;         r = t; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      r         = r & 65535;
      m_gpr[rd] = int'(r);
      m_flags   = {r >= 32768, r == 0, c, v};
    end
  endtask

  task automatic exec(input logic [31:0] ins);
    @(negedge clk);
    instr_in    = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    model_exec(ins);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0];
      #1;
      checks++;
      if (dbg_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_gpr[%0d]: got %h expected 0000", i, dbg_data);
      end
    end
    checks++;
    if (dut_flags !== 4'b0000 || dbg_sgpr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_flags_sgpr: got flags %b sgpr %h expected 0000/0000", dut_flags, dbg_sgpr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_flags_directed();
    for (int k = 0; k < 4; k++) begin
      exec(enc(1, 0, 0, 1'b1, d_a[k]));
      exec(enc(1, 1, 0, 1'b1, d_b[k]));
      exec(enc(d_op[k], 2, 0, 1'b0, 1));
      dbg_addr = 5'd2;
      #1;
      checks++;
      if (dbg_data !== d_res[k][15:0] || dut_flags !== d_fl[k]) begin
        errors++;
        $display("FAIL flags_directed[%0d]: got %h/%b expected %h/%b",
                 k, dbg_data, dut_flags, d_res[k][15:0], d_fl[k]);
      end
      $display("directed %0d: op=%0d result=%h flags=%b", k, d_op[k], dbg_data, dut_flags);
    end
  endtask

  task automatic test_mul();
    exec(enc(1, 0, 0, 1'b1, 'h1234));
    exec(enc(1, 1, 0, 1'b1, 'h0100));
    exec(enc(1, 3, 0, 1'b1, 'h7777));
    exec(enc(1, 5, 0, 1'b1, 'h5555));
    exec(enc(4, 3, 0, 1'b0, 1));
    dbg_addr = 5'd3;
    #1;
    checks++;
`ifdef CPU_MUL_EN
    if (dbg_data !== 16'h3400 || dbg_sgpr !== 16'h0012) begin
      errors++;
      $display("FAIL mul: got rdst %h sgpr %h expected 3400/0012", dbg_data, dbg_sgpr);
    end
`else
    if (dbg_data !== 16'h7777 || dbg_sgpr !== 16'h0000) begin
      errors++;
      $display("FAIL mul_disabled: got rdst %h sgpr %h expected 7777/0000", dbg_data, dbg_sgpr);
    end
`endif
    exec(enc(0, 5, 0, 1'b0, 0));
    dbg_addr = 5'd5;
    #1;
    checks++;
`ifdef CPU_MUL_EN
    if (dbg_data !== 16'h0012) begin
      errors++;
      $display("FAIL movsgpr: got %h expected 0012", dbg_data);
    end
`else
    if (dbg_data !== 16'h5555) begin
      errors++;
      $display("FAIL movsgpr_disabled: got %h expected 5555", dbg_data);
    end
`endif
    $display("mul: rdst path checked, sgpr=%h", dbg_sgpr);
  endtask

  task automatic test_random(input int n);
    logic [31:0] ins;
    int rd;
    for (int t = 0; t < n; t++) begin
      ins        = $urandom;
      ins[31:27] = 5'($urandom_range(0, 15));
      // Keep sources in a small window so results feed back into later operands.
      ins[21:17] = 5'($urandom_range(0, 7));
      if (!ins[16]) ins[15:11] = 5'($urandom_range(0, 7));
      exec(ins);
      rd       = int'(ins[26:22]);
      dbg_addr = ins[26:22];
      #1;
      checks++;
      if (dbg_data !== m_gpr[rd][15:0]) begin
        errors++;
        $display("FAIL random_rd[%0d]: instr %h got %h expected %h", t, ins, dbg_data, m_gpr[rd][15:0]);
      end
      checks++;
      if (dut_flags !== m_flags) begin
        errors++;
        $display("FAIL random_flags[%0d]: instr %h got %b expected %b", t, ins, dut_flags, m_flags);
      end
      checks++;
      if (dbg_sgpr !== m_sgpr[15:0]) begin
        errors++;
        $display("FAIL random_sgpr[%0d]: instr %h got %h expected %h", t, ins, dbg_sgpr, m_sgpr[15:0]);
      end
      $display("txn %0d: instr=%h rd=%0d data=%h flags=%b sgpr=%h", t, ins, rd, dbg_data, dut_flags, dbg_sgpr);
    end
  endtask

  task automatic test_hold();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      instr_in    = $urandom;
      instr_in[31:27] = 5'($urandom_range(1, 11));
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0];
      #1;
      checks++;
      if (dbg_data !== m_gpr[i][15:0]) begin
        errors++;
        $display("FAIL hold_gpr[%0d]: got %h expected %h", i, dbg_data, m_gpr[i][15:0]);
      end
    end
    checks++;
    if (dut_flags !== m_flags || dbg_sgpr !== m_sgpr[15:0]) begin
      errors++;
      $display("FAIL hold_flags_sgpr: got %b/%h expected %b/%h", dut_flags, dbg_sgpr, m_flags, m_sgpr[15:0]);
    end
    $display("hold: 4 idle cycles, state compared");
  endtask

  task automatic test_reset_midrun();
    logic [31:0] ins;
    exec(enc(1, 7, 0, 1'b1, 'h8000));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    dbg_addr = 5'd7;
    #1;
    checks++;
    if (dbg_data !== 16'h0000 || dut_flags !== 4'b0000 || dbg_sgpr !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%h expected 0000/0000/0000", dbg_data, dut_flags, dbg_sgpr);
    end
    // Instruction presented while reset is held must be ignored.
    instr_in    = enc(1, 9, 0, 1'b1, 'h5555);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    dbg_addr = 5'd9;
    #1;
    checks++;
    if (dbg_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_override: got %h expected 0000", dbg_data);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    model_reset();
    exec(enc(1, 4, 0, 1'b1, 'hABCD));
    ins        = $urandom;
    ins[31:27] = 5'd15;
    ins[26:22] = 5'd4;
    exec(ins);
    dbg_addr = 5'd4;
    #1;
    checks++;
    if (dbg_data !== 16'hABCD || dut_flags !== 4'b1000) begin
      errors++;
      $display("FAIL noop15: got %h/%b expected abcd/1000", dbg_data, dut_flags);
    end
    $display("reset midrun: async clear, override and opcode 15 checked");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_flags_directed();
    test_mul();
    test_random(250);
    test_hold();
    test_reset_midrun();
    test_random(50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
